uart_rx_frame_fifo: RTL and testbench

Parametrised UART receive engine for the VGA project's serial command path: oversampled start detection, LSB-first data of runtime-selectable length, optional even/odd parity, one or two stop bits, per-frame error reporting and a small output FIFO with valid/ready handshake. It sits between the `Rx` pin and the command decoder, all in the `clk_16bd` domain. It generalises the current single-frame receiver in width, oversampling ratio and buffering, and adds false-start rejection, error flags and overrun handling.

---
 rtl/uart_rx_frame_fifo.sv | 209 ++++++++++++++++++++
 tb/tb_uart_rx_frame_fifo.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_fifo.sv
// UART receiver: oversampled start detection, configurable data/parity/stop, per-frame error pulses, output FIFO.
// Define UART_RX_MAJORITY_EN to take each bit as a 3-sample majority vote around mid-bit.
`timescale 1ns/1ps
module uart_rx_frame_fifo #(
  parameter int MAX_DATA_BITS = 9,
  parameter int OVERSAMPLE    = 16,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     clk_16bd,
  input  logic                     rst_n,
  input  logic                     Rx,
  input  logic                     parity,
  input  logic                     parity_type,
  input  logic                     stop_bits,
  input  logic [3:0]               frame_length,
  output logic [MAX_DATA_BITS-1:0] frame,
  output logic                     frame_valid,
  input  logic                     frame_ready,
  output logic                     parity_err,
  output logic                     frame_err,
  output logic                     overrun
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [TW-1:0] TICK_M0  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_M1  = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] TICK_DEC = TW'(OVERSAMPLE / 2 + 1);
`else
  localparam logic [TW-1:0] TICK_DEC = TW'(OVERSAMPLE / 2);
`endif

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;

  state_t                   r_state;
  logic                     r_rx_meta, r_rxs;
  logic [TW-1:0]            r_tick;
  logic [3:0]               r_len, r_bit_idx;
  logic                     r_par_en, r_par_odd, r_two_stop;
  logic                     r_par_bit, r_ferr, r_stop_idx;
  logic [MAX_DATA_BITS-1:0] r_data;
  logic                     r_parity_err, r_frame_err, r_overrun;

  logic [MAX_DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]            r_wr_ptr, r_rd_ptr;
  logic [AW:0]              r_count;

  logic       w_bit, w_samp, w_decide, w_ferr_now, w_perr;
  logic       w_full, w_empty, w_push, w_pop;
  logic [3:0] w_len;

  always_ff @(posedge clk_16bd or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rxs     <= 1'b1;
    end else begin
      r_rx_meta <= Rx;
      r_rxs     <= r_rx_meta;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic r_m0, r_m1;
  always_ff @(posedge clk_16bd or negedge rst_n) begin
    if (!rst_n) begin
      r_m0 <= 1'b1;
      r_m1 <= 1'b1;
    end else begin
      if (r_tick == TICK_M0) r_m0 <= r_rxs;
      if (r_tick == TICK_M1) r_m1 <= r_rxs;
    end
  end
  assign w_bit = (r_m0 & r_m1) | (r_m0 & r_rxs) | (r_m1 & r_rxs);
`else
  assign w_bit = r_rxs;
`endif

  assign w_samp     = (r_tick == TICK_DEC);
  assign w_ferr_now = r_ferr | ~w_bit;
  assign w_perr     = r_par_en & (^r_data ^ r_par_bit ^ r_par_odd);
  assign w_decide   = (r_state == S_STOP) && w_samp && (r_stop_idx == r_two_stop);

  always_comb begin
    w_len = frame_length;
    if (frame_length < 4'd5)
      w_len = 4'd5;
    else if (frame_length > 4'(MAX_DATA_BITS))
      w_len = 4'(MAX_DATA_BITS);
  end

  // A pop in the decision cycle frees the slot the new frame needs.
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_pop   = frame_ready & ~w_empty;
  assign w_push  = w_decide & ~w_ferr_now & ~w_perr & (~w_full | w_pop);

  always_ff @(posedge clk_16bd or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_tick       <= '0;
      r_len        <= 4'd5;
      r_bit_idx    <= '0;
      r_par_en     <= 1'b0;
      r_par_odd    <= 1'b0;
      r_two_stop   <= 1'b0;
      r_par_bit    <= 1'b0;
      r_ferr       <= 1'b0;
      r_stop_idx   <= 1'b0;
      r_data       <= '0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
      r_tick       <= (r_tick == TICK_LAST) ? '0 : r_tick + TW'(1);
      case (r_state)
        S_IDLE: begin
          if (!r_rxs) begin
            // Detection cycle counts as tick 0 of the start bit.
            r_tick     <= TW'(1);
            r_len      <= w_len;
            r_par_en   <= parity;
            r_par_odd  <= parity_type;
            r_two_stop <= stop_bits;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_ferr     <= 1'b0;
            r_data     <= '0;
            r_state    <= S_START;
          end
        end
        S_START: begin
          if (w_samp && w_bit)
            r_state <= S_IDLE;
          else if (r_tick == TICK_LAST)
            r_state <= S_DATA;
        end
        S_DATA: begin
          if (w_samp) begin
            for (int i = 0; i < MAX_DATA_BITS; i++)
              if (r_bit_idx == 4'(i)) r_data[i] <= w_bit;
          end
          if (r_tick == TICK_LAST) begin
            if (r_bit_idx == r_len - 4'd1)
              r_state <= r_par_en ? S_PARITY : S_STOP;
            else
              r_bit_idx <= r_bit_idx + 4'd1;
          end
        end
        S_PARITY: begin
          if (w_samp) r_par_bit <= w_bit;
          if (r_tick == TICK_LAST) r_state <= S_STOP;
        end
        S_STOP: begin
          if (w_decide) begin
            if (w_ferr_now) begin
              r_frame_err <= 1'b1;
              r_state     <= S_BREAK;
            end else if (w_perr) begin
              r_parity_err <= 1'b1;
              r_state      <= S_IDLE;
            end else begin
              r_overrun <= w_full & ~w_pop;
              r_state   <= S_IDLE;
            end
          end else begin
            if (w_samp) r_ferr <= w_ferr_now;
            if (r_tick == TICK_LAST) r_stop_idx <= 1'b1;
          end
        end
        S_BREAK: begin
          if (r_rxs) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_16bd) begin
    if (w_push) r_mem[r_wr_ptr] <= r_data;
  end

  always_ff @(posedge clk_16bd or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign frame       = w_empty ? '0 : r_mem[r_rd_ptr];
  assign frame_valid = ~w_empty;
  assign parity_err  = r_parity_err;
  assign frame_err   = r_frame_err;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_uart_rx_frame_fifo.sv
// Directed bench for uart_rx_frame_fifo: table of single frames plus sequences for timing, break, overrun and reset.
`timescale 1ns/1ps
module tb_uart_rx_frame_fifo;
  localparam int OS = 16;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif

  logic       clk = 1'b0, rst_n = 1'b0, rx = 1'b1;
  logic       par = 1'b0, ptype = 1'b0, stop2 = 1'b0, ready = 1'b0;
  logic [3:0] flen = 4'd8;
  logic [8:0] frame;
  logic       fvalid, perr, ferr, ovr;

  always #5 clk = ~clk;

  uart_rx_frame_fifo #(.MAX_DATA_BITS(9), .OVERSAMPLE(OS), .FIFO_DEPTH(4)) dut (
    .clk_16bd(clk), .rst_n(rst_n), .Rx(rx), .parity(par), .parity_type(ptype),
    .stop_bits(stop2), .frame_length(flen), .frame(frame), .frame_valid(fvalid),
    .frame_ready(ready), .parity_err(perr), .frame_err(ferr), .overrun(ovr)
  );

  int n_assert = 0, n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Monitor: pulse/valid cycle counters and log of every accepted frame.
  int perr_n = 0, ferr_n = 0, ovr_n = 0, vcyc_n = 0, pop_n = 0, rise_cyc = 0;
  logic [8:0] popped [0:255];
  logic prev_v = 1'b0;
  always @(negedge clk) begin
    if (perr) perr_n++;
    if (ferr) ferr_n++;
    if (ovr) ovr_n++;
    if (fvalid) vcyc_n++;
    if (fvalid && !prev_v) rise_cyc = cyc;
    prev_v = fvalid;
    if (fvalid && ready && pop_n < 256) begin
      popped[pop_n] = frame;
      pop_n++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end else
      $display("ok   %s: 'h%0h", name, act);
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    for (int c = 0; c < OS; c++) begin
      rx = (glitch && c == OS / 2) ? ~b : b;
      @(posedge clk); #1;
    end
  endtask

  task automatic send_frame(input logic [8:0] data, input int tx_len, input logic [3:0] cfg_len,
                            input logic p_en, input logic p_odd, input logic flip,
                            input logic two_stop, input int bad_stop, input int glitch_bit,
                            input int hold);
    logic pb;
    flen = cfg_len; par = p_en; ptype = p_odd; stop2 = two_stop;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < tx_len; i++) send_bit(data[i], i == glitch_bit);
    if (p_en) begin
      pb = (^data) ^ p_odd ^ flip;
      send_bit(pb, 1'b0);
    end
    send_bit(bad_stop != 1, 1'b0);
    if (two_stop) send_bit(bad_stop != 2, 1'b0);
    if (hold > 0) begin
      rx = 1'b0;
      repeat (hold) @(posedge clk);
      #1;
    end
    rx = 1'b1;
    repeat (2 * OS) @(posedge clk);
    #1;
  endtask

  task automatic send_8n1(input logic [8:0] data);
    send_frame(data, 8, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1, 0);
  endtask

  typedef struct {
    logic [8:0] data;
    int         tx_len;
    logic [3:0] cfg_len;
    logic       p_en, p_odd, flip, two_stop;
    int         bad_stop;
    int         exp_kind;   // 0 accepted, 1 parity error, 2 framing error
    logic [8:0] exp_frame;
  } vec_t;

  vec_t vecs [10];
  int p0, e0, f0, o0, v0, c0;

  initial begin
    vecs[0] = '{9'h05A, 8, 4'd8,  1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 9'h05A};
    vecs[1] = '{9'h1FF, 9, 4'd9,  1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 9'h1FF};
    vecs[2] = '{9'h1FF, 9, 4'd9,  1'b1, 1'b1, 1'b1, 1'b0, 0, 1, 9'h000};
    vecs[3] = '{9'h055, 7, 4'd7,  1'b0, 1'b0, 1'b0, 1'b1, 2, 2, 9'h000};
    vecs[4] = '{9'h015, 5, 4'd5,  1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 9'h015};
    vecs[5] = '{9'h00B, 5, 4'd3,  1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 9'h00B};
    vecs[6] = '{9'h155, 9, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 9'h155};
    vecs[7] = '{9'h0F0, 8, 4'd8,  1'b1, 1'b0, 1'b1, 1'b0, 1, 2, 9'h000};
    vecs[8] = '{9'h02D, 6, 4'd6,  1'b0, 1'b0, 1'b0, 1'b1, 1, 2, 9'h000};
    vecs[9] = '{9'h0C3, 8, 4'd8,  1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 9'h0C3};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset frame", frame, 0);
    check("reset valid", fvalid, 0);
    check("reset pulses", {perr, ferr, ovr}, 0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Single-frame table, consumer always ready
    ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      p0 = pop_n; e0 = perr_n; f0 = ferr_n; o0 = ovr_n; v0 = vcyc_n;
      send_frame(vecs[i].data, vecs[i].tx_len, vecs[i].cfg_len, vecs[i].p_en, vecs[i].p_odd,
                 vecs[i].flip, vecs[i].two_stop, vecs[i].bad_stop, -1, 0);
      check($sformatf("vec%0d frames", i), pop_n - p0, (vecs[i].exp_kind == 0) ? 1 : 0);
      if (vecs[i].exp_kind == 0) check($sformatf("vec%0d data", i), popped[p0], vecs[i].exp_frame);
      check($sformatf("vec%0d valid cycles", i), vcyc_n - v0, (vecs[i].exp_kind == 0) ? 1 : 0);
      check($sformatf("vec%0d parity_err", i), perr_n - e0, (vecs[i].exp_kind == 1) ? 1 : 0);
      check($sformatf("vec%0d frame_err", i), ferr_n - f0, (vecs[i].exp_kind == 2) ? 1 : 0);
      check($sformatf("vec%0d overrun", i), ovr_n - o0, 0);
    end

    // Framing error followed by a line held low for 40 bit periods
    p0 = pop_n; e0 = perr_n; f0 = ferr_n; o0 = ovr_n;
    send_frame(9'h02A, 7, 4'd7, 1'b0, 1'b0, 1'b0, 1'b1, 2, -1, 40 * OS);
    check("break frame_err", ferr_n - f0, 1);
    check("break frames", pop_n - p0, 0);
    check("break other pulses", (perr_n - e0) + (ovr_n - o0), 0);

    // Latency: Rx falling edge to frame_valid rise, also proves recovery from break
    p0 = pop_n;
    c0 = cyc;
    send_8n1(9'h03C);
    check("latency", rise_cyc - c0, 155 + MAJ);
    check("post-break data", popped[p0], 9'h03C);

    // Short idle glitch must be rejected as a false start
    p0 = pop_n; e0 = perr_n; f0 = ferr_n; o0 = ovr_n;
    rx = 1'b0;
    repeat (OS / 2 - 2) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (3 * OS) @(posedge clk);
    #1;
    check("glitch frames", pop_n - p0, 0);
    check("glitch pulses", (perr_n - e0) + (ferr_n - f0) + (ovr_n - o0), 0);

`ifdef UART_RX_MAJORITY_EN
    p0 = pop_n;
    send_frame(9'h0A5, 8, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 0, 3, 0);
    check("majority frames", pop_n - p0, 1);
    check("majority data", popped[p0], 9'h0A5);
`endif

    // Overrun: five frames into a four-entry FIFO with no consumer
    ready = 1'b0;
    p0 = pop_n; o0 = ovr_n; e0 = perr_n; f0 = ferr_n;
    for (int k = 1; k <= 5; k++) send_8n1(9'(k));
    check("ovr pulses", ovr_n - o0, 1);
    check("ovr err pulses", (perr_n - e0) + (ferr_n - f0), 0);
    check("ovr head valid", fvalid, 1);
    check("ovr head data", frame, 9'h001);
    ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    ready = 1'b0;
    check("ovr drain count", pop_n - p0, 4);
    for (int k = 0; k < 4; k++) check($sformatf("ovr drain %0d", k), popped[p0 + k], k + 1);
    check("ovr drained valid", fvalid, 0);

    // Full FIFO with a pop in the very decision cycle: push must succeed
    p0 = pop_n; o0 = ovr_n;
    for (int k = 1; k <= 4; k++) send_8n1(9'(k));
    fork
      send_8n1(9'h005);
      begin
        repeat (154 + MAJ) @(posedge clk);
        #1 ready = 1'b1;
        @(posedge clk);
        #1 ready = 1'b0;
      end
    join
    check("simul overrun", ovr_n - o0, 0);
    check("simul pop count", pop_n - p0, 1);
    check("simul popped", popped[p0], 9'h001);
    ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    ready = 1'b0;
    check("simul drain count", pop_n - p0, 5);
    for (int k = 1; k < 5; k++) check($sformatf("simul drain %0d", k), popped[p0 + k], k + 1);

    // Reset mid-DATA with two frames buffered
    send_8n1(9'h011);
    send_8n1(9'h022);
    check("pre-reset valid", fvalid, 1);
    fork
      send_8n1(9'h033);
      begin
        repeat (60) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("mid-reset valid", fvalid, 0);
        check("mid-reset frame", frame, 0);
      end
    join
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("post-reset valid", fvalid, 0);
    ready = 1'b1;
    p0 = pop_n; e0 = perr_n; f0 = ferr_n; o0 = ovr_n;
    send_8n1(9'h044);
    check("post-reset frames", pop_n - p0, 1);
    check("post-reset data", popped[p0], 9'h044);
    check("post-reset pulses", (perr_n - e0) + (ferr_n - f0) + (ovr_n - o0), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
